bip_acc_datapath: RTL and testbench

Parametrised accumulator datapath for the next-generation BIP core: one accumulator, a multi-function ALU, status flags and an iterative barrel-free shifter. It sits between the BIP control unit (which drives operand, selects, ALU op and write strobe) and data memory (address/data). It replaces the fixed 16-bit add/sub-only datapath. Multi-cycle shifts are exposed to the control unit through `o_busy`.

---
 rtl/bip_pkg.sv | 41 ++++
 rtl/bip_acc_datapath_if.sv | 30 +++
 rtl/bip_alu.sv | 51 +++++
 rtl/bip_acc_datapath.sv | 151 +++++++++++++++
 tb/tb_bip_acc_datapath.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bip_pkg.sv
// Shared encodings for the BIP accumulator datapath: accumulator source
// selects, ALU operations, flag bit positions and shifter FSM states.
package bip_pkg;

  // Accumulator source select
  typedef enum logic [1:0] {
    SEL_A_MEM = 2'd0,
    SEL_A_IMM = 2'd1,
    SEL_A_ALU = 2'd2,
    SEL_A_CLR = 2'd3
  } sel_a_e;

  // ALU B operand select
  localparam logic SEL_B_MEM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  // ALU operations
  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_SHL   = 3'd5,
    ALU_SRA   = 3'd6,
    ALU_PASSB = 3'd7
  } alu_op_e;

  // Bit positions inside the {Z, N, C, V} flag vector
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Shifter sequencing
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } dp_state_e;

endpackage

// File: rtl/bip_acc_datapath_if.sv
// Control-unit / data-memory bus of the accumulator datapath. The master side
// is the control unit (and memory read data), the slave side is the datapath.
interface bip_acc_datapath_if #(
  parameter int DATA_W    = 16,
  parameter int OPERAND_W = 11,
  parameter int ADDR_W    = 11
);

  logic [OPERAND_W-1:0] i_operand;
  logic [1:0]           i_sel_a;
  logic                 i_sel_b;
  logic [2:0]           i_alu_op;
  logic                 i_write_acc;
  logic [DATA_W-1:0]    i_mem_data;
  logic [DATA_W-1:0]    o_mem_data;
  logic [ADDR_W-1:0]    o_mem_address;
  logic                 o_busy;
  logic [3:0]           o_flags;

  modport master (
    output i_operand, i_sel_a, i_sel_b, i_alu_op, i_write_acc, i_mem_data,
    input  o_mem_data, o_mem_address, o_busy, o_flags
  );

  modport slave (
    input  i_operand, i_sel_a, i_sel_b, i_alu_op, i_write_acc, i_mem_data,
    output o_mem_data, o_mem_address, o_busy, o_flags
  );

endinterface

// File: rtl/bip_alu.sv
// Single-cycle ALU of the accumulator datapath. Shift ops are handled by the
// iterative shifter in the top level; here they simply pass A through.
module bip_alu
  import bip_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              ovf_o
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  // Result and carry/overflow selection per operation
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    result_o = a_i;
    carry_o  = 1'b0;
    ovf_o    = 1'b0;
    unique case (op_i)
      ALU_ADD: begin
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
        ovf_o    = (a_i[DATA_W-1] == b_i[DATA_W-1]) &&
                   (sum[DATA_W-1] != a_i[DATA_W-1]);
      end
      ALU_SUB: begin
        // Top bit of the widened difference is the borrow (unsigned a < b)
        result_o = diff[DATA_W-1:0];
        carry_o  = diff[DATA_W];
        ovf_o    = (a_i[DATA_W-1] != b_i[DATA_W-1]) &&
                   (diff[DATA_W-1] != a_i[DATA_W-1]);
      end
      ALU_AND:   result_o = a_i & b_i;
      ALU_OR:    result_o = a_i | b_i;
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_SHL:   result_o = a_i;
      ALU_SRA:   result_o = a_i;
      ALU_PASSB: result_o = b_i;
    endcase
  end

endmodule

// File: rtl/bip_acc_datapath.sv
// BIP accumulator datapath: accumulator register, multi-function ALU,
// {Z,N,C,V} flags and a one-bit-per-cycle shifter that holds o_busy while
// it runs. Writes arriving while busy are dropped, not queued.
module bip_acc_datapath
  import bip_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int OPERAND_W = 11,
  parameter int ADDR_W    = 11
) (
  input  logic               clk,
  input  logic               rst,
  bip_acc_datapath_if.slave  bus
);

  localparam int SHAMT_W = $clog2(DATA_W);

  logic [DATA_W-1:0]  imm_ext;
  logic [DATA_W-1:0]  opnd_b;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_carry;
  logic               alu_ovf;
  logic [SHAMT_W-1:0] shamt;
  alu_op_e            alu_op;
  sel_a_e             sel_a;
  logic               accept;
  logic               refresh_zn;
  logic               shift_out;

  dp_state_e          state_q, state_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [3:0]         flags_q, flags_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               sra_q, sra_d;
  logic               busy_q, busy_d;

  assign imm_ext = {{(DATA_W-OPERAND_W){bus.i_operand[OPERAND_W-1]}}, bus.i_operand};
  assign opnd_b  = (bus.i_sel_b == SEL_B_IMM) ? imm_ext : bus.i_mem_data;
  assign shamt   = opnd_b[SHAMT_W-1:0];
  assign alu_op  = alu_op_e'(bus.i_alu_op);
  assign sel_a   = sel_a_e'(bus.i_sel_a);
  assign accept  = bus.i_write_acc && !busy_q;

  bip_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a_i      (acc_q),
    .b_i      (opnd_b),
    .op_i     (alu_op),
    .result_o (alu_result),
    .carry_o  (alu_carry),
    .ovf_o    (alu_ovf)
  );

  // Next-state: accept a write in IDLE, or step the shifter one bit in SHIFT
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    flags_d    = flags_q;
    count_d    = count_q;
    sra_d      = sra_q;
    busy_d     = busy_q;
    refresh_zn = 1'b0;
    shift_out  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          refresh_zn = 1'b1;
          unique case (sel_a)
            SEL_A_MEM: acc_d = bus.i_mem_data;
            SEL_A_IMM: acc_d = imm_ext;
            SEL_A_CLR: acc_d = '0;
            SEL_A_ALU: begin
              if (alu_op == ALU_SHL || alu_op == ALU_SRA) begin
                if (shamt == '0) begin
                  // Zero-distance shift completes now with acc unchanged
                  flags_d[FLAG_C] = 1'b0;
                  flags_d[FLAG_V] = 1'b0;
                end else begin
                  // Flags stay put until the final shift step
                  refresh_zn = 1'b0;
                  state_d    = ST_SHIFT;
                  count_d    = shamt;
                  sra_d      = (alu_op == ALU_SRA);
                  busy_d     = 1'b1;
                end
              end else begin
                acc_d           = alu_result;
                flags_d[FLAG_C] = alu_carry;
                flags_d[FLAG_V] = alu_ovf;
              end
            end
          endcase
        end
      end
      ST_SHIFT: begin
        if (sra_q) begin
          acc_d     = {acc_q[DATA_W-1], acc_q[DATA_W-1:1]};
          shift_out = acc_q[0];
        end else begin
          acc_d     = {acc_q[DATA_W-2:0], 1'b0};
          shift_out = acc_q[DATA_W-1];
        end
        if (count_q == SHAMT_W'(1)) begin
          state_d         = ST_IDLE;
          busy_d          = 1'b0;
          count_d         = '0;
          refresh_zn      = 1'b1;
          flags_d[FLAG_C] = shift_out;
          flags_d[FLAG_V] = 1'b0;
        end else begin
          count_d = count_q - SHAMT_W'(1);
        end
      end
    endcase

    // Z and N always reflect the value being written
    if (refresh_zn) begin
      flags_d[FLAG_Z] = (acc_d == '0);
      flags_d[FLAG_N] = acc_d[DATA_W-1];
    end
  end

  // Register all datapath and sequencing state; reset aborts any shift at once
  // NOTE: the async reset clears every register, so a mid-shift reset leaves no stale count or direction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      flags_q <= '0;
      count_q <= '0;
      sra_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      state_q <= state_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
      count_q <= count_d;
      sra_q   <= sra_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_mem_data    = acc_q;
  assign bus.o_mem_address = bus.i_operand[ADDR_W-1:0];
  assign bus.o_busy        = busy_q;
  assign bus.o_flags       = flags_q;

endmodule

// File: tb/tb_bip_acc_datapath.sv
// Self-checking bench for bip_acc_datapath (DATA_W=16, OPERAND_W=11, ADDR_W=11).
// A transaction-level model predicts acc/flags/busy every cycle; directed
// literal checks pin the model at the interesting points.
module tb_bip_acc_datapath;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  bip_acc_datapath_if #(.DATA_W(16), .OPERAND_W(11), .ADDR_W(11)) bus ();

  bip_acc_datapath #(
    .DATA_W    (16),
    .OPERAND_W (11),
    .ADDR_W    (11)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [15:0] acc;
    logic [15:0] acc0;   // value when the shift started
    logic [3:0]  flags;  // {Z,N,C,V}
    logic        busy;
    logic        sra;
    logic [4:0]  k;
    logic [4:0]  done;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t cur, logic [1:0] sa, logic sb, logic [2:0] op,
                                        logic [10:0] opnd, logic [15:0] mem, logic wr);
    model_t      n;
    logic [15:0] imm;
    logic [15:0] b;
    logic [16:0] wide;
    logic        cout;
    int          a_s;
    int          b_s;
    int          r;
    n    = cur;
    imm  = {{5{opnd[10]}}, opnd};
    b    = sb ? imm : mem;
    a_s  = int'($signed(cur.acc));
    b_s  = int'($signed(b));
    cout = 1'b0;
    if (cur.busy) begin
      n.done = cur.done + 5'd1;
      if (cur.sra) begin
        n.acc = 16'($signed(cur.acc0) >>> n.done);
        cout  = cur.acc0[n.done - 5'd1];
      end else begin
        n.acc = cur.acc0 << n.done;
        cout  = cur.acc0[5'd16 - n.done];
      end
      if (n.done == cur.k) begin
        n.busy  = 1'b0;
        n.flags = {n.acc == 16'h0, n.acc[15], cout, 1'b0};
      end
    end else if (wr) begin
      if (sa == 2'd2 && (op == 3'd5 || op == 3'd6)) begin
        if (b[3:0] == 4'd0) begin
          n.flags = {cur.acc == 16'h0, cur.acc[15], 2'b00};
        end else begin
          n.busy = 1'b1;
          n.k    = {1'b0, b[3:0]};
          n.done = 5'd0;
          n.sra  = (op == 3'd6);
          n.acc0 = cur.acc;
        end
      end else begin
        case (sa)
          2'd0: n.acc = mem;
          2'd1: n.acc = imm;
          2'd3: n.acc = 16'h0;
          default: begin
            n.flags[1:0] = 2'b00;
            case (op)
              3'd0: begin
                wide       = {1'b0, cur.acc} + {1'b0, b};
                r          = a_s + b_s;
                n.acc      = wide[15:0];
                n.flags[1] = wide[16];
                n.flags[0] = (r > 32767) || (r < -32768);
              end
              3'd1: begin
                r          = a_s - b_s;
                n.acc      = cur.acc - b;
                n.flags[1] = (cur.acc < b);
                n.flags[0] = (r > 32767) || (r < -32768);
              end
              3'd2:    n.acc = cur.acc & b;
              3'd3:    n.acc = cur.acc | b;
              3'd4:    n.acc = cur.acc ^ b;
              default: n.acc = b;
            endcase
          end
        endcase
        n.flags[3] = (n.acc == 16'h0);
        n.flags[2] = n.acc[15];
      end
    end
    return n;
  endfunction

  // Model advances on the same edges as the DUT and resets asynchronously
  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '0;
    else      m <= model_next(m, bus.i_sel_a, bus.i_sel_b, bus.i_alu_op, bus.i_operand,
                              bus.i_mem_data, bus.i_write_acc);
  end

  // Every-cycle comparison on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      check("acc",   32'(bus.o_mem_data),    32'(m.acc));
      check("flags", 32'(bus.o_flags),       32'(m.flags));
      check("busy",  32'(bus.o_busy),        32'(m.busy));
      check("addr",  32'(bus.o_mem_address), 32'(bus.i_operand));
    end
  end

  // ---------------- stimulus ----------------
  // Apply one cycle of control inputs (called 2 time units after a falling edge)
  task automatic cyc(input logic [1:0] sa, input logic sb, input logic [2:0] op,
                     input logic [10:0] opnd, input logic [15:0] mem, input logic wr);
    bus.i_sel_a     = sa;
    bus.i_sel_b     = sb;
    bus.i_alu_op    = op;
    bus.i_operand   = opnd;
    bus.i_mem_data  = mem;
    bus.i_write_acc = wr;
    @(negedge clk);
    #2;
  endtask

  task automatic idle();
    cyc(2'd0, 1'b0, 3'd0, 11'h000, 16'h0000, 1'b0);
  endtask

  task automatic expect_state(input string tag, input logic [15:0] acc, input logic [3:0] flags,
                              input logic busy);
    check({tag, ".acc"},   32'(bus.o_mem_data), 32'(acc));
    check({tag, ".flags"}, 32'(bus.o_flags),    32'(flags));
    check({tag, ".busy"},  32'(bus.o_busy),     32'(busy));
  endtask

  initial begin
    rst             = 1'b0;
    bus.i_sel_a     = 2'd0;
    bus.i_sel_b     = 1'b0;
    bus.i_alu_op    = 3'd0;
    bus.i_operand   = 11'h000;
    bus.i_mem_data  = 16'h0000;
    bus.i_write_acc = 1'b0;
    #12;
    expect_state("reset", 16'h0000, 4'b0000, 1'b0);
    rst = 1'b1;
    idle();

    // Load sign-extended immediate 0x7FF -> 0xFFFF, N set, C/V held at 0
    cyc(2'd1, 1'b1, 3'd0, 11'h7FF, 16'h0000, 1'b1);
    expect_state("ld_imm", 16'hFFFF, 4'b0100, 1'b0);

    // 0x7FFF + 1 -> 0x8000 with signed overflow
    cyc(2'd0, 1'b0, 3'd0, 11'h000, 16'h7FFF, 1'b1);
    cyc(2'd2, 1'b1, 3'd0, 11'h001, 16'h0000, 1'b1);
    expect_state("add_ovf", 16'h8000, 4'b0101, 1'b0);

    // Clear: Z set, C/V held from the add
    cyc(2'd3, 1'b0, 3'd0, 11'h000, 16'h0000, 1'b1);
    expect_state("clr", 16'h0000, 4'b1001, 1'b0);

    // 0 - mem 1 -> 0xFFFF with borrow
    cyc(2'd2, 1'b0, 3'd1, 11'h000, 16'h0001, 1'b1);
    expect_state("sub_borrow", 16'hFFFF, 4'b0110, 1'b0);

    // 0xC000 SHL 2, with a write strobe during busy that must be dropped
    cyc(2'd0, 1'b0, 3'd0, 11'h000, 16'hC000, 1'b1);
    cyc(2'd2, 1'b1, 3'd5, 11'h002, 16'h0000, 1'b1);
    expect_state("shl_e0", 16'hC000, 4'b0110, 1'b1);
    cyc(2'd1, 1'b1, 3'd0, 11'h123, 16'h0000, 1'b1);
    expect_state("shl_e1", 16'h8000, 4'b0110, 1'b1);
    cyc(2'd1, 1'b1, 3'd0, 11'h123, 16'h0000, 1'b1);
    expect_state("shl_e2", 16'h0000, 4'b1010, 1'b0);
    idle();

    // SRA by 0 on 0x8001: single cycle, C cleared
    cyc(2'd0, 1'b0, 3'd0, 11'h000, 16'h8001, 1'b1);
    cyc(2'd2, 1'b1, 3'd6, 11'h000, 16'h0000, 1'b1);
    expect_state("sra0", 16'h8001, 4'b0100, 1'b0);

    // Shift amount taken from low bits of B only: 0x010 -> k = 0
    cyc(2'd2, 1'b1, 3'd5, 11'h010, 16'h0000, 1'b1);
    expect_state("shl16", 16'h8001, 4'b0100, 1'b0);

    // 0x8005 SRA 3 -> 0xF000, last bit out is bit 2 = 1; inputs toggle during busy
    cyc(2'd0, 1'b0, 3'd0, 11'h000, 16'h8005, 1'b1);
    cyc(2'd2, 1'b1, 3'd6, 11'h003, 16'h0000, 1'b1);
    cyc(2'd2, 1'b0, 3'd5, 11'h7FF, 16'h1234, 1'b0);
    cyc(2'd3, 1'b1, 3'd0, 11'h055, 16'hFFFF, 1'b0);
    idle();
    expect_state("sra3", 16'hF000, 4'b0110, 1'b0);

    // Logic ops and PASSB
    cyc(2'd2, 1'b1, 3'd4, 11'h7FF, 16'h0000, 1'b1);
    expect_state("xor", 16'h0FFF, 4'b0000, 1'b0);
    cyc(2'd2, 1'b0, 3'd3, 11'h000, 16'hF000, 1'b1);
    cyc(2'd2, 1'b1, 3'd2, 11'h000, 16'h0000, 1'b1);
    expect_state("and", 16'h0000, 4'b1000, 1'b0);
    cyc(2'd2, 1'b0, 3'd7, 11'h000, 16'h8000, 1'b1);

    // 0x8000 - 1 -> 0x7FFF with overflow, no borrow
    cyc(2'd2, 1'b1, 3'd1, 11'h001, 16'h0000, 1'b1);
    expect_state("sub_ovf", 16'h7FFF, 4'b0001, 1'b0);

    // 0xFFFF + 1 -> 0 with carry
    cyc(2'd1, 1'b1, 3'd0, 11'h7FF, 16'h0000, 1'b1);
    cyc(2'd2, 1'b1, 3'd0, 11'h001, 16'h0000, 1'b1);
    expect_state("add_carry", 16'h0000, 4'b1010, 1'b0);

    // Reset in the middle of a long shift, between clock edges
    cyc(2'd0, 1'b0, 3'd0, 11'h000, 16'h9234, 1'b1);
    cyc(2'd2, 1'b1, 3'd5, 11'h00F, 16'h0000, 1'b1);
    idle();
    check("pre_rst.busy", 32'(bus.o_busy), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    expect_state("mid_rst", 16'h0000, 4'b0000, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    idle();
    expect_state("post_rst", 16'h0000, 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
